// File: rtl/temporal_encoder_pkg.sv
// ----------------------------------------------------------------------------
// temporal_encoder_pkg
//   Shared definitions for the temporal encoder slice: default hypervector
//   geometry, FSM state encoding and a ceil(log2) helper used to size the
//   per-bit bundle counters and the fill counter.
// ----------------------------------------------------------------------------
package temporal_encoder_pkg;

    localparam int unsigned HV_DIMENSION_DEF = 2000;
    localparam int unsigned NGRAM_SIZE_DEF   = 3;
    localparam int unsigned WINDOW_DEF       = 5;

    typedef enum logic [1:0] {
        FILL          = 2'd0,
        ACCUM         = 2'd1,
        OUTPUT_STABLE = 2'd2
    } state_e;

    // Smallest w with 2**w >= v, never less than 1 so vectors stay legal.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/temporal_encoder_hv_bundle_counter.sv
// ----------------------------------------------------------------------------
// hv_bundle_counter
//   One bit lane of the majority bundler. Counts ones of the incoming N-gram
//   bit over a window and presents the majority decision including the
//   current bit; an exact tie resolves to the current bit.
// Ports
//   Clk_CI    clock
//   Reset_RI  asynchronous active-low reset
//   Clr_SI    synchronous clear (wins over En_SI)
//   En_SI     add Bit_DI into the count
//   Bit_DI    current N-gram bit
//   Bit_DO    majority/tie result of count + Bit_DI (combinational)
// ----------------------------------------------------------------------------
module hv_bundle_counter #(
    parameter int unsigned WINDOW    = 5,
    parameter int unsigned CNT_WIDTH = 3
) (
    input  logic Clk_CI,
    input  logic Reset_RI,
    input  logic Clr_SI,
    input  logic En_SI,
    input  logic Bit_DI,
    output logic Bit_DO
);

    localparam logic [CNT_WIDTH+1:0] WIN_L = (CNT_WIDTH + 2)'(WINDOW);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH:0]   w_sum;
    logic [CNT_WIDTH+1:0] w_twice;

    always_comb begin
        w_sum   = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, Bit_DI};
        w_twice = {w_sum, 1'b0};
        if (w_twice > WIN_L)       Bit_DO = 1'b1;
        else if (w_twice == WIN_L) Bit_DO = Bit_DI;
        else                       Bit_DO = 1'b0;
    end

    // The count never exceeds WINDOW, so the truncation below cannot wrap.
    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI)   r_cnt <= '0;
        else if (Clr_SI) r_cnt <= '0;
        else if (En_SI)  r_cnt <= w_sum[CNT_WIDTH-1:0];
    end

endmodule

// File: rtl/temporal_encoder.sv
// ----------------------------------------------------------------------------
// temporal_encoder
//   Forms N-grams by permute-and-bind over the last NGRAM_SIZE accepted
//   spatial hypervectors, bundles WINDOW N-grams by per-bit majority and
//   offers the result to the associative memory with a valid/ready handshake.
// Ports
//   Clk_CI            clock
//   Reset_RI          asynchronous active-low reset
//   FlushIn_SI        synchronous clear of history/counters, beats handshake
//   ValidIn_SI        upstream sample valid
//   ReadyOut_SO       block accepts a sample (registered)
//   HypervectorIn_DI  spatial hypervector, bits [0:HV_DIMENSION-1]
//   ValidOut_SO       query hypervector valid (registered)
//   ReadyIn_SI        downstream ready
//   HypervectorOut_DO bundled query hypervector (registered)
// ----------------------------------------------------------------------------
module temporal_encoder
    import temporal_encoder_pkg::*;
#(
    parameter int unsigned HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int unsigned NGRAM_SIZE   = NGRAM_SIZE_DEF,
    parameter int unsigned WINDOW       = WINDOW_DEF
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    FlushIn_SI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

    localparam int unsigned CNT_WIDTH = ceil_log2(WINDOW + 1);
    localparam int unsigned HIST      = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
    localparam int unsigned FILL_W    = ceil_log2(NGRAM_SIZE);
    localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(NGRAM_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] WIN_LAST  = CNT_WIDTH'(WINDOW - 1);
    // With unigrams there is no history to fill.
    localparam state_e ST_START = (NGRAM_SIZE == 1) ? ACCUM : FILL;

    state_e                  r_state;
    logic [FILL_W-1:0]       r_fill;
    logic [CNT_WIDTH-1:0]    r_win;
    logic                    r_ready;
    logic                    r_valid;
    logic [0:HV_DIMENSION-1] r_hv;
    logic [0:HV_DIMENSION-1] r_hist [1:HIST];
    logic [0:HV_DIMENSION-1] w_rot  [1:HIST];
    logic [0:HV_DIMENSION-1] w_ngram;
    logic [0:HV_DIMENSION-1] w_bundle;
    logic                    w_accept;
    logic                    w_en;
    logic                    w_clr;

    assign w_accept = ValidIn_SI & r_ready & ~FlushIn_SI;
    assign w_en     = w_accept & (r_state == ACCUM);
    assign w_clr    = FlushIn_SI | (w_en & (r_win == WIN_LAST));

    // rho^k(H_k): element i of H_k lands at index i+k (mod HV_DIMENSION).
    if (NGRAM_SIZE > 1) begin : g_rot
        for (genvar k = 1; k < NGRAM_SIZE; k++) begin : g_k
            assign w_rot[k] = {r_hist[k][HV_DIMENSION-k +: k],
                               r_hist[k][0 +: HV_DIMENSION-k]};
        end
    end else begin : g_no_rot
        assign w_rot[1] = '0;
    end

    always_comb begin
        w_ngram = HypervectorIn_DI;
        for (int unsigned k = 1; k < NGRAM_SIZE; k++) begin
            w_ngram = w_ngram ^ w_rot[k];
        end
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            for (int unsigned k = 1; k <= HIST; k++) r_hist[k] <= '0;
        end else if (FlushIn_SI) begin
            for (int unsigned k = 1; k <= HIST; k++) r_hist[k] <= '0;
        end else if (w_accept) begin
            r_hist[1] <= HypervectorIn_DI;
            for (int unsigned k = 2; k <= HIST; k++) r_hist[k] <= r_hist[k-1];
        end
    end

    for (genvar b = 0; b < HV_DIMENSION; b++) begin : g_cnt
        hv_bundle_counter #(
            .WINDOW    (WINDOW),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .Clk_CI   (Clk_CI),
            .Reset_RI (Reset_RI),
            .Clr_SI   (w_clr),
            .En_SI    (w_en),
            .Bit_DI   (w_ngram[b]),
            .Bit_DO   (w_bundle[b])
        );
    end

    always_ff @(posedge Clk_CI or negedge Reset_RI) begin
        if (!Reset_RI) begin
            r_state <= ST_START;
            r_fill  <= '0;
            r_win   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_hv    <= '0;
        end else if (FlushIn_SI) begin
            r_state <= ST_START;
            r_fill  <= '0;
            r_win   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_fill <= r_fill + FILL_W'(1);
                        if ((r_fill + FILL_W'(1)) == FILL_LAST) r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_win == WIN_LAST) begin
                            r_win   <= '0;
                            r_hv    <= w_bundle;
                            r_valid <= 1'b1;
                            r_ready <= 1'b0;
                            r_state <= OUTPUT_STABLE;
                        end else begin
                            r_win <= r_win + CNT_WIDTH'(1);
                        end
                    end
                end
                OUTPUT_STABLE: begin
                    if (ReadyIn_SI) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_START;
                end
            endcase
        end
    end

    assign ReadyOut_SO       = r_ready;
    assign ValidOut_SO       = r_valid;
    assign HypervectorOut_DO = r_hv;

endmodule

// File: tb/tb_temporal_encoder.sv
// ----------------------------------------------------------------------------
// tb_temporal_encoder
//   Four temporal_encoder instances (HV_DIMENSION=8) with different N-gram
//   and window sizes, driven by directed and random stimulus and compared
//   against a queue-based reference model of the N-gram/majority rules.
//   Instance 0: N=1 W=3   Instance 1: N=2 W=1
//   Instance 2: N=1 W=2   Instance 3: N=3 W=5
// ----------------------------------------------------------------------------
module tb_temporal_encoder;

    function automatic int ng_of(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int wn_of(input int g);
        case (g)
            0: return 3;
            1: return 1;
            2: return 2;
            default: return 5;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vin     [4];
    logic       flush_a [4];
    logic       rdyin   [4];
    logic [0:7] hin     [4];
    logic       rdyout  [4];
    logic       vout    [4];
    logic [0:7] hout    [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [0:7] hq [4][$];   // accepted samples since clear, most recent first
    logic [0:7] wq [4][$];   // N-grams of the current window
    bit         mv [4];      // expected ValidOut
    logic [0:7] lo [4];      // expected HypervectorOut

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        temporal_encoder #(
            .HV_DIMENSION (8),
            .NGRAM_SIZE   (ng_of(gi)),
            .WINDOW       (wn_of(gi))
        ) u_dut (
            .Clk_CI            (clk),
            .Reset_RI          (rst_n),
            .FlushIn_SI        (flush_a[gi]),
            .ValidIn_SI        (vin[gi]),
            .ReadyOut_SO       (rdyout[gi]),
            .HypervectorIn_DI  (hin[gi]),
            .ValidOut_SO       (vout[gi]),
            .ReadyIn_SI        (rdyin[gi]),
            .HypervectorOut_DO (hout[gi])
        );
    end

    function automatic logic [0:7] rho(input logic [0:7] x);
        return {x[7], x[0:6]};
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            hq[g].delete();
            wq[g].delete();
            mv[g] = 1'b0;
            lo[g] = '0;
        end
    endtask

    task automatic model_accept(input int g, input logic [0:7] x);
        logic [0:7] gram;
        logic [0:7] r;
        int ones;
        int w;
        w = wn_of(g);
        if (hq[g].size() >= ng_of(g) - 1) begin
            gram = x;
            for (int k = 1; k < ng_of(g); k++) begin
                r = hq[g][k-1];
                for (int j = 0; j < k; j++) r = rho(r);
                gram = gram ^ r;
            end
            wq[g].push_back(gram);
            if (wq[g].size() == w) begin
                for (int i = 0; i < 8; i++) begin
                    ones = 0;
                    for (int n = 0; n < wq[g].size(); n++) ones += int'(wq[g][n][i]);
                    lo[g][i] = (2 * ones > w) ? 1'b1 : (2 * ones == w) ? gram[i] : 1'b0;
                end
                wq[g].delete();
                mv[g] = 1'b1;
            end
        end
        hq[g].push_front(x);
        while (hq[g].size() > ng_of(g) - 1) void'(hq[g].pop_back());
    endtask

    // Offer one sample, waiting (bounded) for ReadyOut; samples #1 after the edge.
    task automatic send(input int g, input logic [0:7] x, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (rdyout[g] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (rdyout[g] === 1'b1);
        if (!ok) return;
        vin[g] = 1'b1;
        hin[g] = x;
        @(posedge clk);
        #1;
        vin[g] = 1'b0;
        model_accept(g, x);
    endtask

    task automatic release_out(input int g);
        @(negedge clk);
        rdyin[g] = 1'b1;
        @(posedge clk);
        #1;
        rdyin[g] = 1'b0;
        mv[g] = 1'b0;
    endtask

    task automatic flush(input int g, input logic [0:7] x);
        @(negedge clk);
        flush_a[g] = 1'b1;
        vin[g] = 1'b1;
        hin[g] = x;
        @(posedge clk);
        #1;
        flush_a[g] = 1'b0;
        vin[g] = 1'b0;
        hq[g].delete();
        wq[g].delete();
        mv[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if (rdyout[g] !== 1'b0 || vout[g] !== 1'b0 || hout[g] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: ready=%b valid=%b hv=%h, need 0 0 00", g, rdyout[g], vout[g], hout[g]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if (rdyout[g] !== 1'b1 || vout[g] !== 1'b0 || hout[g] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: ready=%b valid=%b hv=%h, need 1 0 00", g, rdyout[g], vout[g], hout[g]);
            end
        end
    endtask

    task automatic test_window_majority();
        logic [0:7] stim [3];
        bit ok;
        stim = '{8'hF0, 8'hF0, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            send(0, stim[i], ok);
            n_checks++;
            if (!ok || vout[0] !== mv[0] || hout[0] !== lo[0]) begin
                n_fail++;
                $display("FAIL majority_step%0d: ok=%0d valid=%b hv=%h, need valid=%b hv=%h", i, ok, vout[0], hout[0], mv[0], lo[0]);
            end
        end
        n_checks++;
        if (vout[0] !== 1'b1 || hout[0] !== 8'hF0) begin
            n_fail++;
            $display("FAIL majority_result: valid=%b hv=%h, need 1 f0", vout[0], hout[0]);
        end
        release_out(0);
        n_checks++;
        if (vout[0] !== 1'b0 || rdyout[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL majority_release: valid=%b ready=%b, need 0 1", vout[0], rdyout[0]);
        end
    endtask

    task automatic test_slide();
        bit ok;
        send(1, 8'h80, ok);
        n_checks++;
        if (!ok || vout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL slide_fill: ok=%0d valid=%b, need 0", ok, vout[1]);
        end
        send(1, 8'h00, ok);
        n_checks++;
        if (!ok || vout[1] !== 1'b1 || hout[1] !== 8'h40) begin
            n_fail++;
            $display("FAIL slide_first: ok=%0d valid=%b hv=%h, need 1 40", ok, vout[1], hout[1]);
        end
        release_out(1);
        send(1, 8'h01, ok);
        n_checks++;
        if (!ok || vout[1] !== 1'b1 || hout[1] !== 8'h01) begin
            n_fail++;
            $display("FAIL slide_second: ok=%0d valid=%b hv=%h, need 1 01", ok, vout[1], hout[1]);
        end
        release_out(1);
    endtask

    task automatic test_tie();
        bit ok;
        send(2, 8'hF0, ok);
        send(2, 8'h0F, ok);
        n_checks++;
        if (!ok || vout[2] !== 1'b1 || hout[2] !== 8'h0F) begin
            n_fail++;
            $display("FAIL tie_latest: ok=%0d valid=%b hv=%h, need 1 0f", ok, vout[2], hout[2]);
        end
        release_out(2);
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [0:7] x;
        logic [0:7] held;
        for (int i = 0; i < 3; i++) send(0, 8'($urandom()), ok);
        n_checks++;
        if (!ok || vout[0] !== 1'b1 || hout[0] !== lo[0]) begin
            n_fail++;
            $display("FAIL bp_fill: ok=%0d valid=%b hv=%h, need 1 %h", ok, vout[0], hout[0], lo[0]);
        end
        held = lo[0];
        x = 8'($urandom());
        @(negedge clk);
        vin[0] = 1'b1;
        hin[0] = x;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (vout[0] !== 1'b1 || hout[0] !== held || rdyout[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b hv=%h ready=%b, need 1 %h 0", c, vout[0], hout[0], rdyout[0], held);
            end
        end
        @(negedge clk);
        rdyin[0] = 1'b1;
        @(posedge clk);
        #1;
        rdyin[0] = 1'b0;
        mv[0] = 1'b0;
        n_checks++;
        if (vout[0] !== 1'b0 || rdyout[0] !== 1'b1 || hout[0] !== held) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b hv=%h, need 0 1 %h", vout[0], rdyout[0], hout[0], held);
        end
        @(posedge clk);
        #1;
        vin[0] = 1'b0;
        model_accept(0, x);
        for (int i = 0; i < 2; i++) send(0, 8'($urandom()), ok);
        n_checks++;
        if (!ok || vout[0] !== mv[0] || hout[0] !== lo[0]) begin
            n_fail++;
            $display("FAIL bp_next_window: ok=%0d valid=%b hv=%h, need valid=%b hv=%h", ok, vout[0], hout[0], mv[0], lo[0]);
        end
        release_out(0);
    endtask

    task automatic test_flush();
        bit ok;
        logic [0:7] held;
        for (int i = 0; i < 2; i++) send(3, 8'($urandom()), ok);
        flush(3, 8'($urandom()));
        n_checks++;
        if (vout[3] !== 1'b0 || rdyout[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fill: valid=%b ready=%b, need 0 1", vout[3], rdyout[3]);
        end
        // Two refill samples, then five N-grams close the window.
        for (int i = 0; i < 7; i++) begin
            send(3, 8'($urandom()), ok);
            n_checks++;
            if (!ok || vout[3] !== ((i == 6) ? 1'b1 : 1'b0) || hout[3] !== lo[3]) begin
                n_fail++;
                $display("FAIL flush_refill%0d: ok=%0d valid=%b hv=%h, need valid=%b hv=%h", i, ok, vout[3], hout[3], (i == 6), lo[3]);
            end
        end
        held = lo[3];
        flush(3, 8'($urandom()));
        n_checks++;
        if (vout[3] !== 1'b0 || rdyout[3] !== 1'b1 || hout[3] !== held) begin
            n_fail++;
            $display("FAIL flush_output: valid=%b ready=%b hv=%h, need 0 1 %h", vout[3], rdyout[3], hout[3], held);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        flush(1, 8'($urandom()));
        send(1, 8'h80, ok);
        send(1, 8'h00, ok);
        n_checks++;
        if (!ok || vout[1] !== 1'b1 || hout[1] !== 8'h40) begin
            n_fail++;
            $display("FAIL areset_setup: ok=%0d valid=%b hv=%h, need 1 40", ok, vout[1], hout[1]);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (vout[1] !== 1'b0 || hout[1] !== 8'h00 || rdyout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_async: valid=%b hv=%h ready=%b, need 0 00 0", vout[1], hout[1], rdyout[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            n_checks++;
            if (rdyout[g] !== 1'b1 || vout[g] !== 1'b0 || hout[g] !== 8'h00) begin
                n_fail++;
                $display("FAIL areset_release[%0d]: ready=%b valid=%b hv=%h, need 1 0 00", g, rdyout[g], vout[g], hout[g]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int g;
        int r;
        for (int it = 0; it < 240; it++) begin
            g = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 15));
            if (mv[g]) begin
                for (int c = 0; c < int'($urandom_range(0, 2)); c++) begin
                    @(posedge clk);
                    #1;
                    n_checks++;
                    if (vout[g] !== 1'b1 || hout[g] !== lo[g] || rdyout[g] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_hold[%0d]: valid=%b hv=%h ready=%b, need 1 %h 0", g, vout[g], hout[g], rdyout[g], lo[g]);
                    end
                end
                release_out(g);
                n_checks++;
                if (vout[g] !== 1'b0 || rdyout[g] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_release[%0d]: valid=%b ready=%b, need 0 1", g, vout[g], rdyout[g]);
                end
            end else if (r == 0) begin
                flush(g, 8'($urandom()));
                n_checks++;
                if (vout[g] !== 1'b0 || rdyout[g] !== 1'b1 || hout[g] !== lo[g]) begin
                    n_fail++;
                    $display("FAIL rand_flush[%0d]: valid=%b ready=%b hv=%h, need 0 1 %h", g, vout[g], rdyout[g], hout[g], lo[g]);
                end
            end else begin
                send(g, 8'($urandom()), ok);
                n_checks++;
                if (!ok || vout[g] !== mv[g] || hout[g] !== lo[g]) begin
                    n_fail++;
                    $display("FAIL rand_accept[%0d]: ok=%0d valid=%b hv=%h, need valid=%b hv=%h", g, ok, vout[g], hout[g], mv[g], lo[g]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            vin[g]     = 1'b0;
            flush_a[g] = 1'b0;
            rdyin[g]   = 1'b0;
            hin[g]     = '0;
        end
        model_reset();
        test_reset();
        test_window_majority();
        test_slide();
        test_tie();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
